instr_loader: RTL
=================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter END_WORD, default 32'hFFFF_FFFF: terminator word that ends a load.
REQ-002 Parameter TIMEOUT, default 16: maximum idle cycles allowed inside a partial word.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new load; sampled in IDLE, DONE and ERROR only.
REQ-006 in_valid  input  1  in_data carries a program byte.
REQ-007 in_data  input  8  program byte; stream order is big-endian, first byte is the word MSB.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 fetch_addr  input  8  byte address of the instruction fetch (pc).
REQ-010 fetch_word  output  32  {mem[a], mem[a+1], mem[a+2], mem[a+3]}, where a = fetch_addr.
REQ-011 busy  output  1  high in LOAD.
REQ-012 done  output  1  high in DONE.
REQ-013 error  output  1  high in ERROR.
REQ-014 word_count  output  7  number of complete non-terminator words stored (0..64).

Function
REQ-015 Storage SHALL be a 256 x 8 byte memory, the same layout the datapath fetches from.
REQ-016 FSM states SHALL be IDLE, LOAD, DONE and ERROR.
REQ-017 start in IDLE, DONE or ERROR -> LOAD next cycle, with wr_addr=0, byte_idx=0, word_count=0 and idle counter=0.
REQ-018 start while in LOAD SHALL be ignored.
REQ-019 in_ready SHALL equal (state==LOAD) combinationally.
REQ-020 A byte is accepted only when in_valid && in_ready; it is written to mem[wr_addr] at that edge.
REQ-021 On each accepted byte: wr_addr increments by 1, byte_idx increments modulo 4, and the byte shifts into a 32-bit assembly register.
REQ-022 When the 4th byte of a word is accepted:
  - assembled word == END_WORD -> DONE; word_count unchanged; the terminator bytes remain in memory.
  - otherwise word_count increments; if the new count is 64 -> DONE.
REQ-023 The idle counter increments each LOAD cycle with byte_idx!=0 and no accepted byte, and clears on each accepted byte.
REQ-024 The idle counter reaching TIMEOUT -> ERROR; no timeout applies while byte_idx==0.
REQ-025 fetch_word SHALL be a combinational read; address arithmetic is 8-bit and wraps (fetch_addr=8'hFE reads bytes FE, FF, 00, 01).
REQ-026 A same-cycle write and fetch of the same byte returns the old value until the clock edge.
REQ-027 word_count, done and error SHALL hold their values in DONE and ERROR until the next start or rst.

Reset
REQ-028 rst SHALL force state=IDLE, wr_addr=0, byte_idx=0, word_count=0, idle counter=0 and assembly register=0.
REQ-029 Under rst, in_ready, busy, done and error SHALL all be 0.
REQ-030 Memory contents SHALL NOT be reset; rst during LOAD abandons the load and leaves already-written bytes in place.
REQ-031 rst SHALL take priority over start and over byte acceptance in the same cycle.

Structure
REQ-032 A shared package SHALL hold:
  - the FSM state enum;
  - MEM_BYTES=256 and MAX_WORDS=64;
  - the opcode constants shared with the datapath.
REQ-033 The byte memory SHALL be one sub-module, byte_mem256: one synchronous write port and four combinational read ports.
REQ-034 The FSM, counters and assembly register SHALL live in instr_loader.

Verification
REQ-035 Normal load: start, then bytes 00 22 18 00, 18 43 00 05, FF FF FF FF.
  - Required: done=1, word_count=2.
  - Required: fetch_addr=0 -> 32'h0022_1800; fetch_addr=4 -> 32'h1843_0005.
REQ-036 Backpressure: in_valid toggled randomly.
  - Required: only bytes with in_valid && in_ready are stored.
  - Required: in_ready=0 in IDLE and DONE; bytes offered there leave memory unchanged.
REQ-037 Full: 64 non-terminator words streamed.
  - Required: done=1 and word_count=64 after byte 256.
  - Required: in_ready=0; a 257th byte is not written.
REQ-038 Timeout: 2 bytes, then 16 idle cycles.
  - Required: error=1 on the cycle the counter reaches TIMEOUT.
  - Required: a following start returns to LOAD with word_count=0.
REQ-039 Reset mid-load: rst asserted after 6 bytes.
  - Required: next cycle state IDLE, all outputs 0.
  - Required: mem[0..5] retain the streamed values; start together with rst stays IDLE.
REQ-040 Wrap read: mem[FE..FF]=AA BB and mem[00..01]=CC DD; fetch_addr=8'hFE -> fetch_word=32'hAABB_CCDD.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and constants for the instruction loader
package instr_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } load_state_e;

    localparam int MEM_BYTES = 256;
    localparam int MAX_WORDS = 64;

    // Opcode byte values shared with the datapath decoder
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LOADI = 8'h18;
    localparam logic [7:0] OP_ADD   = 8'h22;
    localparam logic [7:0] OP_SUB   = 8'h23;
    localparam logic [7:0] OP_JMP   = 8'h43;
    localparam logic [7:0] OP_HALT  = 8'hFF;

endpackage

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - byte stream and instruction fetch bundle
interface instr_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  fetch_addr;
    logic [31:0] fetch_word;

    modport master (
        output in_valid, in_data, fetch_addr,
        input  in_ready, fetch_word
    );

    modport slave (
        input  in_valid, in_data, fetch_addr,
        output in_ready, fetch_word
    );
endinterface

// File: rtl/byte_mem256.sv
// rtl/byte_mem256.sv - 256x8 program memory, one sync write port, four async read ports
module byte_mem256
    import instr_loader_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr0,
    input  logic [7:0] raddr1,
    input  logic [7:0] raddr2,
    input  logic [7:0] raddr3,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic [7:0] rdata2,
    output logic [7:0] rdata3
);

    // Contents are deliberately not reset so a program survives a loader reset
    logic [7:0] mem_q [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata0 = mem_q[raddr0];
    assign rdata1 = mem_q[raddr1];
    assign rdata2 = mem_q[raddr2];
    assign rdata3 = mem_q[raddr3];

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - streams program bytes into memory and serves 32-bit fetches
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter logic [31:0] END_WORD = 32'hFFFF_FFFF,
    parameter int          TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    instr_loader_if.slave    bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [6:0]       word_count
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    load_state_e        state_q,      state_d;
    logic [7:0]         wr_addr_q,    wr_addr_d;
    logic [1:0]         byte_idx_q,   byte_idx_d;
    logic [6:0]         word_count_q, word_count_d;
    logic [IDLE_W-1:0]  idle_cnt_q,   idle_cnt_d;
    logic [31:0]        asm_q,        asm_d;

    logic       accept;
    logic [7:0] fa1, fa2, fa3;
    logic [7:0] rd0, rd1, rd2, rd3;

    // Reset also closes the byte port so a byte offered alongside rst is dropped
    assign bus.in_ready = (state_q == ST_LOAD) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    assign busy       = (state_q == ST_LOAD)  && !rst;
    assign done       = (state_q == ST_DONE)  && !rst;
    assign error      = (state_q == ST_ERROR) && !rst;
    assign word_count = word_count_q;

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        byte_idx_d   = byte_idx_q;
        word_count_d = word_count_q;
        idle_cnt_d   = idle_cnt_q;
        asm_d        = asm_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    wr_addr_d    = 8'd0;
                    byte_idx_d   = 2'd0;
                    word_count_d = 7'd0;
                    idle_cnt_d   = '0;
                    asm_d        = 32'd0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_addr_d  = wr_addr_q + 8'd1;
                    byte_idx_d = byte_idx_q + 2'd1;
                    idle_cnt_d = '0;
                    asm_d      = {asm_q[23:0], bus.in_data};
                    if (byte_idx_q == 2'd3) begin
                        if (asm_d == END_WORD) begin
                            state_d = ST_DONE;
                        end else begin
                            word_count_d = word_count_q + 7'd1;
                            if (word_count_d == 7'(MAX_WORDS)) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end else if (byte_idx_q != 2'd0) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                    if (idle_cnt_d == IDLE_W'(TIMEOUT)) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_addr_q    <= 8'd0;
            byte_idx_q   <= 2'd0;
            word_count_q <= 7'd0;
            idle_cnt_q   <= '0;
            asm_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            byte_idx_q   <= byte_idx_d;
            word_count_q <= word_count_d;
            idle_cnt_q   <= idle_cnt_d;
            asm_q        <= asm_d;
        end
    end

    assign fa1 = bus.fetch_addr + 8'd1;
    assign fa2 = bus.fetch_addr + 8'd2;
    assign fa3 = bus.fetch_addr + 8'd3;

    byte_mem256 u_mem (
        .clk    (clk),
        .we     (accept),
        .waddr  (wr_addr_q),
        .wdata  (bus.in_data),
        .raddr0 (bus.fetch_addr),
        .raddr1 (fa1),
        .raddr2 (fa2),
        .raddr3 (fa3),
        .rdata0 (rd0),
        .rdata1 (rd1),
        .rdata2 (rd2),
        .rdata3 (rd3)
    );

    assign bus.fetch_word = {rd0, rd1, rd2, rd3};

endmodule
